median_filter_unit_v2: RTL

Parametrised successor to the memory-mapped 3x3 median filter unit. A host loads a greyscale image into a source buffer and programs width, height and border mode through a single memory-style port. It then starts the engine, polls status, and reads the filtered image back from a separate destination buffer. Pixel width, address depth and bus width are parameters. Source and destination buffers are split, so input data is never overwritten. New relative to the fixed unit: selectable border handling, error/busy status and a readable progress counter.

---
 rtl/median_filter_unit_v2_pkg.sv | 27 ++
 rtl/median_filter_unit_v2_median9_sort.sv | 46 ++++
 rtl/median_filter_unit_v2.sv | 174 +++++++++++++++++
 3 files changed

// File: rtl/median_filter_unit_v2_pkg.sv
// median_filter_unit_v2_pkg: shared widths, region codes, control/status bits and engine states.
package median_filter_unit_v2_pkg;
  localparam int DEF_PIX_W  = 8;
  localparam int DEF_DATA_W = 32;
  localparam int DEF_ADDR_W = 18;
  localparam int DEF_MODE_W = 2;
  localparam logic [1:0] MODE_PIX    = 2'b00;
  localparam logic [1:0] MODE_CTRL   = 2'b01;
  localparam logic [1:0] MODE_WIDTH  = 2'b10;
  localparam logic [1:0] MODE_HEIGHT = 2'b11;
  localparam int CTRL_START  = 0;
  localparam int CTRL_BORDER = 1;
  localparam int STAT_DONE   = 0;
  localparam int STAT_BUSY   = 1;
  localparam int STAT_ERR    = 2;
  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_FETCH   = 3'd1,
    S_CAPTURE = 3'd2,
    S_SORT    = 3'd3,
    S_WRITE   = 3'd4,
    S_DONE    = 3'd5
  } state_t;
  function automatic logic dims_ok(input logic [15:0] w, input logic [15:0] h, input int addr_w);
    return w >= 16'd3 && h >= 16'd3 && 64'(w) * 64'(h) <= (64'd1 << addr_w);
  endfunction
endpackage

// File: rtl/median_filter_unit_v2_median9_sort.sv
// median_filter_unit_v2_median9_sort: 2-cycle pipelined median of 9 unsigned pixels.
module median_filter_unit_v2_median9_sort #(
  parameter int PIX_W = 8
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic [8:0][PIX_W-1:0] win_i,
  output logic [PIX_W-1:0]      med_o
);
  logic [2:0][PIX_W-1:0] lo_q, lo_d, mi_q, mi_d, hi_q, hi_d;
  logic [PIX_W-1:0] med_q, med_d;
  function automatic logic [PIX_W-1:0] mn(input logic [PIX_W-1:0] a, input logic [PIX_W-1:0] b);
    return a < b ? a : b;
  endfunction
  function automatic logic [PIX_W-1:0] mx(input logic [PIX_W-1:0] a, input logic [PIX_W-1:0] b);
    return a < b ? b : a;
  endfunction
  function automatic logic [PIX_W-1:0] md(input logic [PIX_W-1:0] a, input logic [PIX_W-1:0] b,
                                          input logic [PIX_W-1:0] c);
    return mx(mn(a, b), mn(mx(a, b), c));
  endfunction
  // Sort each triple, then the median is the median of max-of-lows, median-of-mids, min-of-highs.
  always_comb begin
    for (int r = 0; r < 3; r++) begin
      lo_d[r] = mn(mn(win_i[3*r], win_i[3*r+1]), win_i[3*r+2]);
      mi_d[r] = md(win_i[3*r], win_i[3*r+1], win_i[3*r+2]);
      hi_d[r] = mx(mx(win_i[3*r], win_i[3*r+1]), win_i[3*r+2]);
    end
    med_d = md(mx(mx(lo_q[0], lo_q[1]), lo_q[2]), md(mi_q[0], mi_q[1], mi_q[2]),
               mn(mn(hi_q[0], hi_q[1]), hi_q[2]));
  end
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      lo_q  <= '0;
      mi_q  <= '0;
      hi_q  <= '0;
      med_q <= '0;
    end else begin
      lo_q  <= lo_d;
      mi_q  <= mi_d;
      hi_q  <= hi_d;
      med_q <= med_d;
    end
  end
  assign med_o = med_q;
endmodule

// File: rtl/median_filter_unit_v2.sv
// median_filter_unit_v2: host-mapped 3x3 median filter with split source/destination buffers.
module median_filter_unit_v2
  import median_filter_unit_v2_pkg::*;
#(
  parameter int PIX_W  = DEF_PIX_W,
  parameter int DATA_W = DEF_DATA_W,
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int MODE_W = DEF_MODE_W
) (
  input  logic                     CLK,
  input  logic                     RST,
  input  logic [DATA_W-1:0]        dina_i,
  input  logic [MODE_W+ADDR_W-1:0] addra_i,
  input  logic                     wea_i,
  input  logic                     ena_i,
  output logic [DATA_W-1:0]        douta_o
);
  logic [PIX_W-1:0] src_mem [2**ADDR_W];
  logic [PIX_W-1:0] dst_mem [2**ADDR_W];
  state_t state_q, state_d;
  logic [15:0] wid_q, wid_d, hgt_q, hgt_d, row_q, row_d, col_q, col_d, cc;
  logic [ADDR_W-1:0] base_q, base_d, host_addr, eng_addr, pix_addr, rb;
  logic [ADDR_W:0] cnt_q, cnt_d;
  logic [1:0] wr_q, wr_d, wc_q, wc_d, ewr, ewc, mode;
  logic border_q, border_d, done_q, done_d, err_q, err_d, rv_q, rv_d, s_q, s_d;
  logic [8:0][PIX_W-1:0] win_q, win_d;
  logic [PIX_W-1:0] src_rd_q, src_rd_d, med;
  logic [DATA_W-1:0] douta_q, douta_d;
  logic [2:0] stat;
  logic busy, host_wr, host_rd, is_med, last_col, last_row, start, ok;
  logic unused_bits;
  assign unused_bits = ^dina_i;
  median_filter_unit_v2_median9_sort #(.PIX_W(PIX_W)) u_sort (
    .CLK  (CLK),
    .RST  (RST),
    .win_i(win_q),
    .med_o(med)
  );
  always_comb begin
    mode      = addra_i[ADDR_W+MODE_W-1 -: 2];
    host_addr = addra_i[ADDR_W-1:0];
    busy      = state_q inside {S_FETCH, S_CAPTURE, S_SORT, S_WRITE};
    host_wr   = ena_i & wea_i;
    host_rd   = ena_i & ~wea_i;
    last_col  = col_q == wid_q - 16'd1;
    last_row  = row_q == hgt_q - 16'd1;
    is_med    = border_q | (row_q != '0 && !last_row && col_q != '0 && !last_col);
    // Window walks rows/cols -1..+1 with edge clamping; a copy pixel fetches only the centre.
    ewr       = is_med ? wr_q : 2'd1;
    ewc       = is_med ? wc_q : 2'd1;
    rb        = ewr == 2'd0 && row_q != '0 ? base_q - ADDR_W'(wid_q) :
                ewr == 2'd2 && !last_row ? base_q + ADDR_W'(wid_q) : base_q;
    cc        = ewc == 2'd0 && col_q != '0 ? col_q - 16'd1 :
                ewc == 2'd2 && !last_col ? col_q + 16'd1 : col_q;
    eng_addr  = rb + ADDR_W'(cc);
    pix_addr  = base_q + ADDR_W'(col_q);
    src_rd_d  = src_mem[eng_addr];
    start     = host_wr && mode == MODE_CTRL && host_addr == '0 && dina_i[CTRL_START] && !busy;
    ok        = dims_ok(wid_q, hgt_q, ADDR_W);
    stat             = '0;
    stat[STAT_DONE]  = done_q;
    stat[STAT_BUSY]  = busy;
    stat[STAT_ERR]   = err_q;
    douta_d   = !host_rd ? douta_q :
                mode == MODE_PIX ? (busy ? '0 : DATA_W'(dst_mem[host_addr])) :
                mode == MODE_WIDTH ? DATA_W'(wid_q) :
                mode == MODE_HEIGHT ? DATA_W'(hgt_q) :
                host_addr == ADDR_W'(0) ? DATA_W'(stat) :
                host_addr == ADDR_W'(1) ? DATA_W'(cnt_q) : '0;
  end
  always_comb begin
    state_d  = state_q;
    wid_d    = host_wr && !busy && mode == MODE_WIDTH ? dina_i[15:0] : wid_q;
    hgt_d    = host_wr && !busy && mode == MODE_HEIGHT ? dina_i[15:0] : hgt_q;
    row_d    = row_q;
    col_d    = col_q;
    base_d   = base_q;
    cnt_d    = cnt_q;
    wr_d     = wr_q;
    wc_d     = wc_q;
    border_d = border_q;
    done_d   = done_q;
    err_d    = err_q;
    s_d      = s_q;
    rv_d     = state_q == S_FETCH;
    win_d    = rv_q ? {win_q[7:0], src_rd_q} : win_q;
    case (state_q)
      S_IDLE, S_DONE: begin
        state_d = S_IDLE;
        if (start) begin
          border_d = dina_i[CTRL_BORDER];
          cnt_d    = '0;
          row_d    = '0;
          col_d    = '0;
          base_d   = '0;
          wr_d     = '0;
          wc_d     = '0;
          done_d   = !ok;
          err_d    = !ok;
          state_d  = ok ? S_FETCH : S_IDLE;
        end
      end
      S_FETCH: begin
        state_d = !is_med || (wr_q == 2'd2 && wc_q == 2'd2) ? S_CAPTURE : S_FETCH;
        wc_d    = wc_q == 2'd2 ? 2'd0 : wc_q + 2'd1;
        wr_d    = wc_q == 2'd2 ? wr_q + 2'd1 : wr_q;
      end
      S_CAPTURE: begin
        state_d = is_med ? S_SORT : S_WRITE;
        s_d     = 1'b0;
      end
      S_SORT: begin
        s_d     = 1'b1;
        state_d = s_q ? S_WRITE : S_SORT;
      end
      S_WRITE: begin
        cnt_d   = cnt_q + 1'b1;
        wr_d    = '0;
        wc_d    = '0;
        col_d   = last_col ? '0 : col_q + 16'd1;
        row_d   = last_col ? row_q + 16'd1 : row_q;
        base_d  = last_col ? base_q + ADDR_W'(wid_q) : base_q;
        done_d  = last_col && last_row;
        state_d = last_col && last_row ? S_DONE : S_FETCH;
      end
      default: state_d = S_IDLE;
    endcase
  end
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q  <= S_IDLE;
      wid_q    <= '0;
      hgt_q    <= '0;
      row_q    <= '0;
      col_q    <= '0;
      base_q   <= '0;
      cnt_q    <= '0;
      wr_q     <= '0;
      wc_q     <= '0;
      border_q <= 1'b0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
      rv_q     <= 1'b0;
      s_q      <= 1'b0;
      win_q    <= '0;
      src_rd_q <= '0;
      douta_q  <= '0;
    end else begin
      state_q  <= state_d;
      wid_q    <= wid_d;
      hgt_q    <= hgt_d;
      row_q    <= row_d;
      col_q    <= col_d;
      base_q   <= base_d;
      cnt_q    <= cnt_d;
      wr_q     <= wr_d;
      wc_q     <= wc_d;
      border_q <= border_d;
      done_q   <= done_d;
      err_q    <= err_d;
      rv_q     <= rv_d;
      s_q      <= s_d;
      win_q    <= win_d;
      src_rd_q <= src_rd_d;
      douta_q  <= douta_d;
    end
  end
  // Buffers are not reset; host pixel writes only land while idle so they never meet engine traffic.
  always_ff @(posedge CLK) begin
    if (host_wr && !busy && mode == MODE_PIX) src_mem[host_addr] <= dina_i[PIX_W-1:0];
    if (state_q == S_WRITE) dst_mem[pix_addr] <= is_med ? med : win_q[0];
  end
  assign douta_o = douta_q;
endmodule
